mem_line_responder: RTL and testbench

Main-memory side of the cache-to-memory line bus: the responder that serves whole-cacheline READ_LINE and WRITE_LINE requests issued by the 2-way cache on a miss or dirty eviction. It holds a byte-addressed backing store of 2^ADDR_LINE_BITS lines, models a fixed access latency, and transfers each 16-byte line as 8 consecutive 16-bit beats. It sits directly below the cache and is the only agent answering on this bus.

---
 rtl/mem_line_responder.sv | 153 +++++++++++++++
 tb/tb_mem_line_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_responder.sv
// Memory-side responder for the cache line bus: serves whole-line READ_LINE and
// WRITE_LINE requests after a fixed latency, moving each line as 8 sequential beats.
module mem_line_responder #(
   parameter int ADDR_LINE_BITS = 15,
   parameter int LINE_BYTES     = 16,
   parameter int BUS_BITS       = 16,
   parameter int LATENCY        = 100
) (
   input  logic                      clk,
   input  logic                      R,
   input  logic [ADDR_LINE_BITS-1:0] A2,
   input  logic [1:0]                C2_in,
   input  logic [BUS_BITS-1:0]       D2_in,
   output logic [1:0]                C2_out,
   output logic [BUS_BITS-1:0]       D2_out,
   output logic                      busy
);

   localparam int LINE_BITS = LINE_BYTES * 8;
   localparam int BEATS     = LINE_BITS / BUS_BITS;
   localparam int BEAT_W    = $clog2(BEATS);
   localparam int OFF_BITS  = $clog2(LINE_BYTES);
   localparam int CNT_W     = $clog2(LATENCY + 1);
   localparam int WBUF_BITS = LINE_BITS - BUS_BITS;

   localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(LATENCY - 2);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      CMD_NOP   = 2'd0,
      CMD_RSVD  = 2'd1,
      CMD_READ  = 2'd2,
      CMD_WRITE = 2'd3
   } cmd_e;

   typedef enum logic [1:0] {
      RSP_NOP  = 2'd0,
      RSP_DONE = 2'd1
   } rsp_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_RECV = 3'd1,
      WAIT    = 3'd2,
      RD_SEND = 3'd3,
      WR_ACK  = 3'd4
   } state_e;

   state_e                    state, state_nxt;
   cmd_e                      cmd;
   logic                      accept;
   logic                      is_write;
   logic                      commit;
   logic [CNT_W-1:0]          cnt;
   logic [BEAT_W-1:0]         beat_idx;
   logic [ADDR_LINE_BITS-1:0] addr_q;
   logic [WBUF_BITS-1:0]      wbuf;
   logic [LINE_BITS-1:0]      rd_line;
   logic [LINE_BITS-1:0]      mem [0:(2**ADDR_LINE_BITS)-1];

   // Power-up contents of a line: byte at byte address a holds a[7:0] ^ a[15:8];
   // beat k carries byte 2k in its upper half and byte 2k+1 in its lower half.
   function automatic logic [LINE_BITS-1:0] line_pattern(input logic [ADDR_LINE_BITS-1:0] la);
      logic [15:0] a16;
      line_pattern = '0;
      for (int b = 0; b < LINE_BYTES; b++) begin
         a16 = 16'({la, OFF_BITS'(b)});
         line_pattern[(b / 2) * BUS_BITS + ((b % 2 == 0) ? 8 : 0) +: 8] = a16[7:0] ^ a16[15:8];
      end
   endfunction

   assign cmd    = cmd_e'(C2_in);
   assign accept = (cmd == CMD_READ) || (cmd == CMD_WRITE);
   assign commit = (state == WR_RECV) && (beat_idx == LAST_BEAT) && !R;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (R) state <= IDLE;
      else   state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      C2_out    = RSP_NOP;
      D2_out    = '0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (cmd == CMD_READ)       state_nxt = WAIT;
            else if (cmd == CMD_WRITE) state_nxt = WR_RECV;
         end
         WR_RECV: if (beat_idx == LAST_BEAT) state_nxt = WAIT;
         WAIT:    if (cnt == WAIT_LAST) state_nxt = is_write ? WR_ACK : RD_SEND;
         RD_SEND: begin
            C2_out = RSP_DONE;
            D2_out = rd_line[int'(beat_idx) * BUS_BITS +: BUS_BITS];
            if (beat_idx == LAST_BEAT) state_nxt = IDLE;
         end
         WR_ACK: begin
            C2_out    = RSP_DONE;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The counter runs from the accept edge through beat capture and the wait,
   // so the response lands LATENCY cycles after accept for both commands.
   always_ff @(posedge clk) begin
      if (R) begin
         cnt      <= '0;
         beat_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q   <= A2;
                  cnt      <= '0;
                  is_write <= (cmd == CMD_WRITE);
                  if (cmd == CMD_WRITE) begin
                     wbuf[BUS_BITS-1:0] <= D2_in;
                     beat_idx           <= BEAT_W'(1);
                  end else begin
                     beat_idx <= '0;
                  end
               end
            end
            WR_RECV: begin
               cnt      <= cnt + CNT_W'(1);
               beat_idx <= beat_idx + BEAT_W'(1);
               if (beat_idx != LAST_BEAT)
                  wbuf[int'(beat_idx) * BUS_BITS +: BUS_BITS] <= D2_in;
            end
            WAIT:    cnt      <= cnt + CNT_W'(1);
            RD_SEND: beat_idx <= beat_idx + BEAT_W'(1);
            default: ;
         endcase
      end
   end

   // NOTE: the backing store is deliberately not reset; lines survive R.
   // It holds the difference from the power-up pattern, so a zero-initialised
   // simulation array reads back as that pattern until a line is written.
   always_ff @(posedge clk) begin
      if (commit) mem[addr_q] <= {D2_in, wbuf} ^ line_pattern(addr_q);
   end

   assign rd_line = mem[addr_q] ^ line_pattern(addr_q);

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: a byte-level memory model predicts every
// response beat and its cycle; a negedge monitor compares what two DUTs present.
module tb_mem_line_responder;

   localparam int AW       = 15;
   localparam int N_RANDOM = 40;

   typedef struct {
      int          inst;
      int          cyc;
      logic [15:0] data;
   } resp_t;

   logic                clk = 1'b0;
   logic [1:0]          r_i;
   logic [1:0][AW-1:0]  a_i;
   logic [1:0][1:0]     c2_i;
   logic [1:0][15:0]    d_i;
   logic [1:0][1:0]     c2_o;
   logic [1:0][15:0]    d2_o;
   logic [1:0]          busy_o;

   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b0;

   resp_t       exp_q[$];
   logic [7:0]  mem_m [int];
   int          busy_from [2];
   int          busy_until[2];
   int          wr_t      [2];
   bit          wr_active [2];
   logic [AW-1:0] wr_addr [2];
   logic [15:0] wr_beats  [2][8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_line_responder #(.LATENCY(100)) u_dut0 (
      .clk(clk), .R(r_i[0]), .A2(a_i[0]), .C2_in(c2_i[0]), .D2_in(d_i[0]),
      .C2_out(c2_o[0]), .D2_out(d2_o[0]), .busy(busy_o[0]));

   mem_line_responder #(.LATENCY(9)) u_dut1 (
      .clk(clk), .R(r_i[1]), .A2(a_i[1]), .C2_in(c2_i[1]), .D2_in(d_i[1]),
      .C2_out(c2_o[1]), .D2_out(d2_o[1]), .busy(busy_o[1]));

   task automatic check(string name, int inst, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst%0d cycle %0d: got 0x%0h expected 0x%0h", name, inst, cyc, act, exp);
      end
   endtask

   function automatic int lat_of(int i);
      return (i == 0) ? 100 : 9;
   endfunction

   function automatic int key_of(int i, logic [AW-1:0] a, int b);
      logic [18:0] ba;
      ba = {a, 4'(b)};
      return (i << 20) | int'(ba);
   endfunction

   function automatic logic [7:0] model_byte(int i, logic [AW-1:0] a, int b);
      logic [15:0] lo;
      int          key;
      lo  = 16'({a, 4'(b)});
      key = key_of(i, a, b);
      if (mem_m.exists(key)) return mem_m[key];
      return lo[7:0] ^ lo[15:8];
   endfunction

   // Applies what the rising edge ending the current cycle does to the model.
   task automatic model_step(int i, logic r, logic [1:0] cmd, logic [AW-1:0] a, logic [15:0] d);
      int l;
      l = lat_of(i);
      if (r) begin
         for (int k = exp_q.size() - 1; k >= 0; k--)
            if (exp_q[k].inst == i && exp_q[k].cyc > cyc) exp_q.delete(k);
         wr_active[i] = 1'b0;
         if (busy_until[i] > cyc + 1) busy_until[i] = cyc + 1;
      end else if (wr_active[i]) begin
         wr_beats[i][cyc - wr_t[i]] = d;
         if (cyc - wr_t[i] == 7) begin
            for (int k = 0; k < 8; k++) begin
               mem_m[key_of(i, wr_addr[i], 2 * k)]     = wr_beats[i][k][15:8];
               mem_m[key_of(i, wr_addr[i], 2 * k + 1)] = wr_beats[i][k][7:0];
            end
            wr_active[i] = 1'b0;
         end
      end else if (cyc >= busy_until[i] && (cmd == 2'd2 || cmd == 2'd3)) begin
         busy_from[i] = cyc + 1;
         if (cmd == 2'd3) begin
            wr_active[i]   = 1'b1;
            wr_t[i]        = cyc;
            wr_addr[i]     = a;
            wr_beats[i][0] = d;
            exp_q.push_back('{i, cyc + l, 16'h0000});
            busy_until[i]  = cyc + l + 1;
         end else begin
            for (int k = 0; k < 8; k++)
               exp_q.push_back('{i, cyc + l + k, {model_byte(i, a, 2 * k), model_byte(i, a, 2 * k + 1)}});
            busy_until[i] = cyc + l + 8;
         end
      end
   endtask

   task automatic do_cycle(int i, logic r, logic [1:0] cmd, logic [AW-1:0] a, logic [15:0] d);
      for (int j = 0; j < 2; j++) begin
         r_i[j]  = (j == i) ? r : 1'b0;
         c2_i[j] = (j == i) ? cmd : 2'd0;
         a_i[j]  = (j == i) ? a : AW'($urandom);
         d_i[j]  = (j == i) ? d : 16'($urandom);
         model_step(j, r_i[j], c2_i[j], a_i[j], d_i[j]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_all(int n);
      for (int k = 0; k < n; k++) begin
         for (int j = 0; j < 2; j++) begin
            r_i[j]  = 1'b1;
            c2_i[j] = 2'd2 + 2'($urandom_range(1));
            a_i[j]  = AW'($urandom);
            d_i[j]  = 16'($urandom);
            model_step(j, 1'b1, c2_i[j], a_i[j], d_i[j]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(int i, int n);
      for (int k = 0; k < n; k++) do_cycle(i, 1'b0, 2'd0, AW'($urandom), 16'($urandom));
   endtask

   task automatic run_until(int i, int target);
      while (cyc < target) do_cycle(i, 1'b0, 2'd0, AW'($urandom), 16'($urandom));
   endtask

   task automatic do_read(int i, logic [AW-1:0] a);
      do_cycle(i, 1'b0, 2'd2, a, 16'($urandom));
   endtask

   // Presents the 8 write beats; abort_at >= 0 raises R in that beat cycle instead.
   task automatic do_write(int i, logic [AW-1:0] a, logic [127:0] w, int abort_at);
      for (int k = 0; k < 8; k++) begin
         if (k == abort_at) begin
            do_cycle(i, 1'b1, 2'd3, a, w[k*16 +: 16]);
            return;
         end
         do_cycle(i, 1'b0, 2'd3, a, w[k*16 +: 16]);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 2; i++) begin
            int idx;
            idx = -1;
            for (int k = 0; k < exp_q.size(); k++)
               if (idx < 0 && exp_q[k].inst == i) idx = k;
            check("busy", i, 32'(busy_o[i]), 32'(cyc >= busy_from[i] && cyc < busy_until[i]));
            if (c2_o[i] != 2'd0) begin
               if (idx < 0) begin
                  check("c2_out_spurious", i, 32'(c2_o[i]), 32'd0);
               end else begin
                  check("c2_out", i, 32'(c2_o[i]), 32'd1);
                  check("resp_cycle", i, cyc, exp_q[idx].cyc);
                  check("resp_data", i, 32'(d2_o[i]), 32'(exp_q[idx].data));
                  exp_q.delete(idx);
               end
            end else begin
               check("d2_out_nop", i, 32'(d2_o[i]), 32'd0);
               if (idx >= 0 && exp_q[idx].cyc <= cyc) begin
                  check("resp_missing", i, 32'(c2_o[i]), 32'd1);
                  exp_q.delete(idx);
               end
            end
         end
      end
   end

   initial begin
      logic [127:0] w;
      int           s;

      r_i  = '1;
      c2_i = '0;
      a_i  = '0;
      d_i  = '0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      reset_all(3);

      // Read of line 1 returns its power-up bytes 0x10..0x1F.
      do_read(0, 15'h0001);
      run_until(0, busy_until[0]);

      // Write top line with 0xA0A1..0xAEAF, then read it back.
      for (int k = 0; k < 8; k++) w[k*16 +: 16] = {8'(8'hA0 + 2 * k), 8'(8'hA1 + 2 * k)};
      do_write(0, 15'h7FFF, w, -1);
      run_until(0, busy_until[0]);
      do_read(0, 15'h7FFF);
      run_until(0, busy_until[0]);

      // Writes presented while a read is in progress are ignored.
      s = cyc;
      do_read(0, 15'h0005);
      while (cyc < busy_until[0]) begin
         if (cyc == s + 5 || cyc == s + 50) do_cycle(0, 1'b0, 2'd3, 15'h0005, 16'hDEAD);
         else                               do_cycle(0, 1'b0, 2'd0, 15'h0005, 16'hBEEF);
      end
      do_cycle(0, 1'b0, 2'd1, 15'h0005, 16'h1234);
      do_read(0, 15'h0005);
      run_until(0, busy_until[0]);

      // Reset in beat cycle 4 aborts the write; the line keeps its old contents.
      w = {$urandom, $urandom, $urandom, $urandom};
      do_write(0, 15'h0002, w, 4);
      idle(0, 1);
      do_read(0, 15'h0002);
      run_until(0, busy_until[0]);

      // Reset 20 cycles into a write: no ack, but the committed line persists.
      w = {$urandom, $urandom, $urandom, $urandom};
      s = cyc;
      do_write(0, 15'h0003, w, -1);
      run_until(0, s + 20);
      do_cycle(0, 1'b1, 2'd0, 15'h0003, 16'h0000);
      do_read(0, 15'h0003);
      run_until(0, busy_until[0]);

      // A request in the last response cycle is dropped; one in the first idle cycle is taken.
      do_read(0, 15'h0010);
      run_until(0, busy_until[0] - 1);
      do_cycle(0, 1'b0, 2'd3, 15'h0010, 16'hFFFF);
      do_read(0, 15'h0011);
      run_until(0, busy_until[0]);

      // Minimum latency: write, then a read in the first idle cycle.
      w = {$urandom, $urandom, $urandom, $urandom};
      do_write(1, 15'h1234, w, -1);
      run_until(1, busy_until[1]);
      do_read(1, 15'h1234);
      run_until(1, busy_until[1]);

      for (int n = 0; n < N_RANDOM; n++) begin
         int            i;
         logic [AW-1:0] a;
         i = ($urandom_range(3) == 0) ? 0 : 1;
         a = ($urandom_range(1) == 0) ? AW'($urandom_range(3)) : AW'($urandom);
         w = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(1) == 1)
            do_write(i, a, w, ($urandom_range(7) == 0) ? int'($urandom_range(7, 1)) : -1);
         else
            do_read(i, a);
         while (cyc < busy_until[i]) begin
            if ($urandom_range(i == 0 ? 499 : 49) == 0)
               do_cycle(i, 1'b1, 2'($urandom), a, 16'($urandom));
            else if ($urandom_range(9) == 0)
               do_cycle(i, 1'b0, 2'($urandom), AW'($urandom), 16'($urandom));
            else
               do_cycle(i, 1'b0, 2'd0, AW'($urandom), 16'($urandom));
         end
         idle(i, $urandom_range(2));
      end

      idle(0, 4);
      check("exp_queue_empty", 0, exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
